// File: rtl/fetch_ctrl_pkg.sv
// Shared RV32I types for the fetch stage: PC mux select encoding,
// fetch sequencer state and the reset value of the instruction hold buffer.
package pcmux;
   typedef enum logic [1:0] {
      pc_plus4 = 2'b00,
      alu_out  = 2'b01,
      alu_mod2 = 2'b10
   } pcmux_sel_t;
endpackage

package rv32i_types;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      HOLD   = 2'b10,
      SQUASH = 2'b11
   } fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues imem reads, drives PC load/mux select,
// buffers an instruction across decode stalls and squashes fetches on redirect.
module fetch_ctrl #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        pc_i,
   input  logic [31:0]        imem_rdata_i,
   input  logic               imem_resp_i,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  pcmux::pcmux_sel_t  redirect_sel_i,
   output logic               imem_read_o,
   output logic [31:0]        imem_addr_o,
   output logic               load_pc_o,
   output pcmux::pcmux_sel_t  pcmux_sel_o,
   output logic               instr_valid_o,
   output logic [31:0]        instr_o,
   output logic [31:0]        instr_pc_o
);
   import pcmux::*;
   import rv32i_types::*;

   fetch_state_t state, state_nxt;
   logic [31:0]  addr_q, addr_nxt;
   logic [31:0]  instr_q, instr_nxt;
   logic         accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         addr_q  <= 32'h0;
         instr_q <= NOP_INSTR;
      end else begin
         state   <= state_nxt;
         addr_q  <= addr_nxt;
         instr_q <= instr_nxt;
      end
   end

   // Redirect masks validity, so a redirect cycle never hands IF/ID an instruction.
   always_comb begin
      imem_read_o   = (state == BUSY) || (state == SQUASH);
      imem_addr_o   = addr_q;
      instr_pc_o    = addr_q;
      instr_o       = (state == HOLD) ? instr_q : imem_rdata_i;
      instr_valid_o = !redirect_i &&
                      (((state == BUSY) && imem_resp_i) || (state == HOLD));
      accept        = instr_valid_o && !stall_i;
      load_pc_o     = redirect_i || accept;
      pcmux_sel_o   = redirect_i ? redirect_sel_i : pc_plus4;
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_q;
      instr_nxt = instr_q;
      unique case (state)
         IDLE: begin
            if (!redirect_i) begin
               addr_nxt  = pc_i;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (redirect_i) begin
               // Without the response the read must still complete and be discarded.
               state_nxt = imem_resp_i ? IDLE : SQUASH;
            end else if (imem_resp_i) begin
               if (stall_i) begin
                  instr_nxt = imem_rdata_i;
                  state_nxt = HOLD;
               end else begin
                  addr_nxt  = pc_i + 32'd4;
               end
            end
         end
         HOLD: begin
            if (redirect_i) begin
               state_nxt = IDLE;
            end else if (!stall_i) begin
               addr_nxt  = pc_i + 32'd4;
               state_nxt = BUSY;
            end
         end
         SQUASH: begin
            if (imem_resp_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage.
- Issues instruction-memory reads and holds the address stable for each outstanding request.
- Drives the PC register's load enable and the PC mux select.
- Buffers a fetched instruction while the decode side is stalled.
- Discards the in-flight fetch when execute redirects the PC.
- Sits between the PC register/PC mux, the instruction memory port and the IF/ID pipeline register.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013: reset/idle value of the instruction hold buffer.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- pc_i  in  32  current PC register output.
- imem_rdata_i  in  32  instruction memory read data.
- imem_resp_i  in  1  instruction memory response; rdata valid this cycle.
- stall_i  in  1  IF/ID cannot accept an instruction this cycle.
- redirect_i  in  1  execute stage requests a PC redirect this cycle.
- redirect_sel_i  in  pcmux::pcmux_sel_t  target select for the redirect (alu_out or alu_mod2).
- imem_read_o  out  1  read request; held high until imem_resp_i.
- imem_addr_o  out  32  read address; stable while imem_read_o is high.
- load_pc_o  out  1  PC register load enable.
- pcmux_sel_o  out  pcmux::pcmux_sel_t  PC mux select.
- instr_valid_o  out  1  instr_o and instr_pc_o are valid for IF/ID.
- instr_o  out  32  fetched instruction.
- instr_pc_o  out  32  PC of instr_o (equals imem_addr_o).

## Operation
- State register fetch_state_t holds one of IDLE, BUSY, HOLD or SQUASH.
- Registers:
  - addr_q (32): address of the current request.
  - instr_q (32): hold buffer for a stalled instruction.
- Combinational outputs:
  - imem_read_o = (BUSY or SQUASH).
  - imem_addr_o = instr_pc_o = addr_q.
  - instr_o = (state==HOLD) ? instr_q : imem_rdata_i.
  - instr_valid_o = !redirect_i && ((BUSY && imem_resp_i) || HOLD).
  - pcmux_sel_o = redirect_i ? redirect_sel_i : pc_plus4.
- accept = instr_valid_o && !stall_i.
- load_pc_o = redirect_i || accept.
- Redirect has priority over stall and over any response. The redirect cycle never presents a valid instruction.
- IDLE:
  - addr_q <= pc_i; next state BUSY.
  - If redirect_i: load the PC and stay IDLE.
- BUSY:
  - Waiting for imem_resp_i: stay BUSY; with redirect_i, go to SQUASH.
  - imem_resp_i with redirect_i: go to IDLE.
  - imem_resp_i with stall_i: instr_q <= imem_rdata_i; go to HOLD; no PC load.
  - imem_resp_i and accepted: addr_q <= pc_i + 4 (mod 2^32, wraps); stay BUSY. This gives back-to-back fetch at 1 instruction/cycle with a zero-wait memory.
- HOLD:
  - stall_i: stay HOLD.
  - !stall_i: instruction is accepted; addr_q <= pc_i + 4; go to BUSY.
  - redirect_i: drop instr_q; go to IDLE.
- SQUASH:
  - imem_read_o stays high at the old addr_q; the response is discarded.
  - On imem_resp_i: go to IDLE.
  - A further redirect_i without a response: load the PC and stay SQUASH.
  - A further redirect_i together with the response: go to IDLE.
- Invariant: in BUSY and HOLD, addr_q == pc_i. In SQUASH, pc_i already holds the redirect target.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, addr_q=0, instr_q=NOP_INSTR.
  - Outputs: imem_read_o=0, imem_addr_o=0, load_pc_o=0 (no redirect), instr_valid_o=0, instr_o=imem_rdata_i, pcmux_sel_o=pc_plus4.
- First request is issued in the cycle after reset deassertion plus one (IDLE→BUSY).
- Fetch latency = memory latency. The instruction is presented combinationally in its response cycle.
- Redirect penalty:
  - From BUSY/HOLD: one IDLE cycle, then the request from the new PC.
  - From BUSY with no response: wait for the response, then IDLE, then the request.
- The PC updates at the clock edge that ends a cycle with load_pc_o high. A new addr_q is sampled from pc_i only in IDLE or as pc_i+4 on accept.
- Reset asserted mid-request: state returns to IDLE immediately and imem_read_o drops. The memory treats the dropped read as abandoned.

## Structure
- fetch_state_t enum goes into rv32i_types, alongside the existing pcmux::pcmux_sel_t.
- NOP_INSTR constant goes into rv32i_types.
- No sub-module. The PC register and PC mux remain outside; this block only drives load_pc_o and pcmux_sel_o.

## Test plan
- Reset, pc_i=0x60, zero-wait memory, no stall:
  - Requests are issued at 0x60, 0x64, 0x68 on consecutive cycles.
  - instr_valid_o=1 and load_pc_o=1 each cycle, with pcmux_sel_o=pc_plus4.
- Response at 0x60 with stall_i high for 3 cycles:
  - HOLD; instr_o equals the buffered rdata; load_pc_o=0.
  - After release: one accept, then a request at 0x64.
- redirect_i with sel=alu_out while waiting 2 cycles for a response:
  - load_pc_o=1 and instr_valid_o=0 that cycle; state SQUASH.
  - The stale response is dropped; IDLE; the next request uses the new pc_i.
- redirect_i coincident with a response in BUSY:
  - instr_valid_o=0; pcmux_sel_o=redirect_sel_i; the next state is IDLE.
- pc_i=0xFFFF_FFFC accepted:
  - The next addr_q is 0x0000_0000.
- rst dropped while imem_read_o is high:
  - All outputs return to their reset values asynchronously.
